scale_round_ctrl: RTL and testbench

SCALE_ROUND_CTRL -- requirements
Module: scale_round_ctrl

---
 rtl/scale_round_ctrl_pkg.sv | 17 +
 rtl/round_watchdog.sv | 39 +++
 rtl/scale_round_ctrl.sv | 137 +++++++++++++
 tb/tb_scale_round_ctrl.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/scale_round_ctrl_pkg.sv
// Shared types and constants for the scale/detect round controller.
package scale_round_ctrl_pkg;

   localparam int ROUND_W       = 5;
   localparam int ADDR_W        = 19;
   localparam int DEF_MAX_ROUND = 17;
   localparam int DEF_TIMEOUT   = 307200;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_SCALE  = 3'd1,
      ST_OFFER  = 3'd2,
      ST_DETECT = 3'd3,
      ST_FINISH = 3'd4
   } state_e;

endpackage

// File: rtl/round_watchdog.sv
// Per-round cycle watchdog: counts while enabled, restarts on clear, pulses expired at LIMIT.
module round_watchdog
   import scale_round_ctrl_pkg::*;
#(
   parameter int unsigned LIMIT = DEF_TIMEOUT
) (
   input  logic clk,
   input  logic rst,
   input  logic clear,
   input  logic count,
   output logic expired
);

   localparam logic [ADDR_W-1:0] LAST_CNT = ADDR_W'(LIMIT - 1);

   logic [ADDR_W-1:0] cnt_q;
   logic [ADDR_W-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clear) begin
         cnt_d = '0;
      end else if (count) begin
         cnt_d = cnt_q + ADDR_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   // Fires on the LIMIT-th counted cycle since the last clear.
   assign expired = count && (cnt_q == LAST_CNT);

endmodule

// File: rtl/scale_round_ctrl.sv
// Sequences an image pyramid: scales each round, hands it to the detector, and
// advances until last_round, with abort, range checking and a per-round watchdog.
module scale_round_ctrl
   import scale_round_ctrl_pkg::*;
#(
   parameter int unsigned MAX_ROUND = DEF_MAX_ROUND,
   parameter int unsigned TIMEOUT   = DEF_TIMEOUT
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic [ROUND_W-1:0] first_round,
   input  logic [ROUND_W-1:0] last_round,
   input  logic               abort,
   output logic               scaler_en,
   output logic [ROUND_W-1:0] round_scale,
   input  logic               scale_done,
   output logic               det_valid,
   input  logic               det_ready,
   input  logic               det_done,
   output logic               busy,
   output logic               pass_done,
   output logic               error
);

   localparam logic [ROUND_W-1:0] MAX_R = ROUND_W'(MAX_ROUND);

   state_e             state_q, state_d;
   logic [ROUND_W-1:0] round_q, round_d;
   logic [ROUND_W-1:0] first_q, first_d;
   logic [ROUND_W-1:0] last_q, last_d;
   logic               error_q, error_d;
   logic               range_ok;
   logic               wd_clear;
   logic               wd_count;
   logic               wd_expired;

   assign range_ok = (first_round <= last_round) && (last_round <= MAX_R);

   always_comb begin
      state_d = state_q;
      round_d = round_q;
      first_d = first_q;
      last_d  = last_q;
      error_d = error_q;
      if (abort) begin
         state_d = ST_IDLE;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (start) begin
                  if (range_ok) begin
                     first_d = first_round;
                     last_d  = last_round;
                     round_d = first_round;
                     error_d = 1'b0;
                     state_d = ST_SCALE;
                  end else begin
                     error_d = 1'b1;
                  end
               end
            end
            ST_SCALE: begin
               if (wd_expired) begin
                  error_d = 1'b1;
                  state_d = ST_IDLE;
               end else if (scale_done) begin
                  state_d = ST_OFFER;
               end
            end
            ST_OFFER: begin
               if (det_ready) begin
                  state_d = ST_DETECT;
               end
            end
            ST_DETECT: begin
               if (wd_expired) begin
                  error_d = 1'b1;
                  state_d = ST_IDLE;
               end else if (det_done) begin
                  // Out-of-range index also finishes, so round_scale can never pass last_q or wrap.
                  if ((round_q >= last_q) || (round_q < first_q)) begin
                     state_d = ST_FINISH;
                  end else begin
                     round_d = round_q + ROUND_W'(1);
                     state_d = ST_SCALE;
                  end
               end
            end
            ST_FINISH: begin
               state_d = ST_IDLE;
            end
            default: begin
               state_d = ST_IDLE;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         round_q <= '0;
         first_q <= '0;
         last_q  <= '0;
         error_q <= 1'b0;
      end else begin
         state_q <= state_d;
         round_q <= round_d;
         first_q <= first_d;
         last_q  <= last_d;
         error_q <= error_d;
      end
   end

   // Any state change restarts the round budget.
   assign wd_clear = (state_d != state_q);
   assign wd_count = (state_q == ST_SCALE) || (state_q == ST_DETECT);

   round_watchdog #(
      .LIMIT(TIMEOUT)
   ) u_watchdog (
      .clk     (clk),
      .rst     (rst),
      .clear   (wd_clear),
      .count   (wd_count),
      .expired (wd_expired)
   );

   assign busy        = (state_q != ST_IDLE);
   assign scaler_en   = (state_q == ST_SCALE);
   assign det_valid   = (state_q == ST_OFFER);
   assign pass_done   = (state_q == ST_FINISH);
   assign round_scale = busy ? round_q : '0;
   assign error       = error_q;

endmodule

// File: tb/tb_scale_round_ctrl.sv
// Scenario-driven bench: each pass is described by its range and handshake delays,
// and the expected per-cycle outputs are derived from that description.
module tb_scale_round_ctrl;

   localparam int MAXR = 17;
   localparam int TMO  = 8;

   logic       clk = 1'b0;
   logic       rst;
   logic       start;
   logic [4:0] first_round;
   logic [4:0] last_round;
   logic       abort;
   logic       scaler_en;
   logic [4:0] round_scale;
   logic       scale_done;
   logic       det_valid;
   logic       det_ready;
   logic       det_done;
   logic       busy;
   logic       pass_done;
   logic       error;

   int vectors     = 0;
   int miscompares = 0;

   logic       e_en, e_dv, e_busy, e_pd, e_err, prev_err;
   logic [4:0] e_rs;
   int         pass_cyc;
   int         abort_at;

   always #5 clk = ~clk;

   scale_round_ctrl #(
      .MAX_ROUND (MAXR),
      .TIMEOUT   (TMO)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .start       (start),
      .first_round (first_round),
      .last_round  (last_round),
      .abort       (abort),
      .scaler_en   (scaler_en),
      .round_scale (round_scale),
      .scale_done  (scale_done),
      .det_valid   (det_valid),
      .det_ready   (det_ready),
      .det_done    (det_done),
      .busy        (busy),
      .pass_done   (pass_done),
      .error       (error)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, got, exp);
      end
   endtask

   task automatic check_outputs();
      chk("scaler_en", 32'(scaler_en), 32'(e_en));
      chk("round_scale", 32'(round_scale), 32'(e_rs));
      chk("det_valid", 32'(det_valid), 32'(e_dv));
      chk("busy", 32'(busy), 32'(e_busy));
      chk("pass_done", 32'(pass_done), 32'(e_pd));
      chk("error", 32'(error), 32'(e_err));
   endtask

   // One clock: abort (if scheduled now) overrides whatever the caller expected.
   task automatic step(output bit ab);
      ab    = (pass_cyc == abort_at);
      abort = ab;
      @(posedge clk);
      #1;
      if (ab) begin
         e_en   = 1'b0;
         e_rs   = '0;
         e_dv   = 1'b0;
         e_busy = 1'b0;
         e_pd   = 1'b0;
         e_err  = prev_err;
      end
      check_outputs();
      prev_err   = e_err;
      start      = 1'b0;
      scale_done = 1'b0;
      det_done   = 1'b0;
      abort      = 1'b0;
      pass_cyc++;
   endtask

   task automatic idle(input int n);
      bit ab;
      abort_at = -1;
      for (int i = 0; i < n; i++) step(ab);
   endtask

   task automatic noise(input bit allow_sd, input bit allow_dd);
      if ($urandom_range(3, 0) == 0) begin
         start       = 1'b1;
         first_round = 5'($urandom_range(17, 0));
         last_round  = 5'($urandom_range(17, 0));
      end
      if (allow_sd && $urandom_range(3, 0) == 0) scale_done = 1'b1;
      if (allow_dd && $urandom_range(3, 0) == 0) det_done = 1'b1;
   endtask

   task automatic apply_reset();
      rst         = 1'b1;
      start       = 1'b1;
      first_round = 5'd0;
      last_round  = 5'd1;
      @(posedge clk);
      #1;
      rst        = 1'b0;
      start      = 1'b0;
      abort      = 1'b0;
      scale_done = 1'b0;
      det_done   = 1'b0;
      det_ready  = 1'b0;
      e_en = 1'b0; e_rs = '0; e_dv = 1'b0; e_busy = 1'b0; e_pd = 1'b0; e_err = 1'b0;
      check_outputs();
      prev_err = 1'b0;
   endtask

   task automatic timeout_expect();
      e_en = 1'b0; e_rs = '0; e_dv = 1'b0; e_busy = 1'b0; e_pd = 1'b0; e_err = 1'b1;
   endtask

   task automatic run_pass(input int fr, input int lr, input int ab_at,
                           input int sd_lo, input int sd_hi,
                           input int rdy_lo, input int rdy_hi,
                           input int dd_lo, input int dd_hi);
      bit ab;
      int k;
      pass_cyc    = 0;
      abort_at    = ab_at;
      start       = 1'b1;
      first_round = 5'(fr);
      last_round  = 5'(lr);
      if (!(fr <= lr && lr <= MAXR)) begin
         e_err = 1'b1;
         step(ab);
         return;
      end
      e_en = 1'b1; e_rs = 5'(fr); e_busy = 1'b1; e_err = 1'b0; e_dv = 1'b0; e_pd = 1'b0;
      step(ab);
      if (ab) return;
      for (int r = fr; r <= lr; r++) begin
         k = int'($urandom_range(sd_hi, sd_lo));
         for (int i = 0; i < TMO; i++) begin
            if (i != k) noise(1'b0, 1'b1);
            else scale_done = 1'b1;
            if (i == TMO - 1) begin
               timeout_expect();
               step(ab);
               return;
            end
            if (i == k) begin
               e_en = 1'b0; e_dv = 1'b1;
               step(ab);
               if (ab) return;
               break;
            end
            step(ab);
            if (ab) return;
         end
         k = int'($urandom_range(rdy_hi, rdy_lo));
         for (int i = 0; i < k; i++) begin
            noise(1'b1, 1'b1);
            step(ab);
            if (ab) return;
         end
         det_ready = 1'b1;
         e_dv      = 1'b0;
         step(ab);
         det_ready = 1'b0;
         if (ab) return;
         k = int'($urandom_range(dd_hi, dd_lo));
         for (int i = 0; i < TMO; i++) begin
            if (i != k) noise(1'b1, 1'b0);
            else det_done = 1'b1;
            if (i == TMO - 1) begin
               timeout_expect();
               step(ab);
               return;
            end
            if (i == k) begin
               if (r == lr) begin
                  e_pd = 1'b1;
                  step(ab);
                  if (ab) return;
                  e_pd = 1'b0; e_busy = 1'b0; e_rs = '0;
                  step(ab);
                  return;
               end
               e_en = 1'b1; e_rs = 5'(r + 1);
               step(ab);
               if (ab) return;
               break;
            end
            step(ab);
            if (ab) return;
         end
      end
   endtask

   initial begin
      bit ab;
      int fr, lr, ab_at;
      rst = 1'b1; start = 1'b0; abort = 1'b0; scale_done = 1'b0;
      det_ready = 1'b0; det_done = 1'b0; first_round = '0; last_round = '0;
      prev_err = 1'b0; pass_cyc = 0; abort_at = -1;
      repeat (2) @(posedge clk);
      apply_reset();

      // illegal ranges, then reset clears the sticky error
      run_pass(5, 2, -1, 0, 0, 0, 0, 0, 0);
      idle(2);
      run_pass(3, 20, -1, 0, 0, 0, 0, 0, 0);
      idle(2);
      apply_reset();

      run_pass(3, 3, -1, 6, 6, 0, 0, 5, 5);
      idle(2);
      run_pass(0, 17, -1, 0, 6, 0, 3, 0, 6);
      idle(2);
      run_pass(7, 8, -1, 1, 1, 20, 20, 2, 2);
      idle(2);

      // watchdog in SCALE, legal restart clears error; watchdog in DETECT
      run_pass(4, 6, -1, 9, 9, 0, 0, 0, 0);
      idle(2);
      run_pass(4, 5, -1, 2, 2, 1, 1, 3, 3);
      idle(2);
      run_pass(1, 1, -1, 0, 0, 0, 0, 9, 9);
      idle(2);

      // abort together with scale_done, with final det_done, and with start
      run_pass(2, 5, 4, 3, 3, 0, 0, 0, 0);
      idle(2);
      run_pass(0, 0, 3, 0, 0, 0, 0, 0, 0);
      idle(2);
      run_pass(1, 2, 0, 0, 0, 0, 0, 0, 0);
      idle(2);

      // reset in the middle of DETECT, alongside abort, start and det_done
      abort_at = -1; pass_cyc = 0;
      start = 1'b1; first_round = 5'd2; last_round = 5'd4;
      e_en = 1'b1; e_rs = 5'd2; e_busy = 1'b1; e_err = 1'b0; e_dv = 1'b0; e_pd = 1'b0;
      step(ab);
      scale_done = 1'b1; e_en = 1'b0; e_dv = 1'b1;
      step(ab);
      det_ready = 1'b1; e_dv = 1'b0;
      step(ab);
      det_ready = 1'b0;
      det_done  = 1'b1;
      abort     = 1'b1;
      apply_reset();
      idle(2);

      for (int n = 0; n < 40; n++) begin
         fr = int'($urandom_range(MAXR, 0));
         lr = int'($urandom_range(MAXR + 3, fr));
         if ($urandom_range(9, 0) == 0 && fr > 0) lr = fr - 1;
         ab_at = ($urandom_range(3, 0) == 0) ? int'($urandom_range(40, 0)) : -1;
         run_pass(fr, lr, ab_at, 0, 8, 0, 4, 0, 8);
         idle(int'($urandom_range(3, 1)));
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
